// File: rtl/mem_pkg.sv
// Shared definitions for the data memory arbiter: FSM encoding and default widths.
package mem_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_LOCK0 = 2'd1,
    ST_LOCK1 = 2'd2
  } arb_state_e;

  localparam int unsigned DEF_ADDR_W = 64;
  localparam int unsigned DEF_DATA_W = 64;

endpackage

// File: rtl/rr_arb2.sv
// Combinational 2-way round-robin pick; i_Prio names the port that wins a tie.
module rr_arb2 (
  input  logic i_Req0,
  input  logic i_Req1,
  input  logic i_Prio,
  output logic o_Pick0,
  output logic o_Pick1
);

  assign o_Pick0 = i_Req0 & (~i_Req1 | ~i_Prio);
  assign o_Pick1 = i_Req1 & (~i_Req0 |  i_Prio);

endmodule

// File: rtl/dmem_arbiter.sv
// Two-port round-robin arbiter with lock in front of the single-ported data_mem.
// Grants are combinational; read data returns registered one cycle after the grant.
module dmem_arbiter
  import mem_pkg::*;
#(
  parameter int unsigned P_ADDR_W = DEF_ADDR_W,
  parameter int unsigned P_DATA_W = DEF_DATA_W
) (
  input  logic                i_Clock,
  input  logic                i_Reset,
  input  logic                i_Req0,
  input  logic                i_Req1,
  input  logic                i_We0,
  input  logic                i_We1,
  input  logic                i_Lock0,
  input  logic                i_Lock1,
  input  logic [P_ADDR_W-1:0] i_Addr0,
  input  logic [P_ADDR_W-1:0] i_Addr1,
  input  logic [P_DATA_W-1:0] i_Wdata0,
  input  logic [P_DATA_W-1:0] i_Wdata1,
  output logic                o_Gnt0,
  output logic                o_Gnt1,
  output logic                o_Rvalid0,
  output logic                o_Rvalid1,
  output logic [P_DATA_W-1:0] o_Rdata0,
  output logic [P_DATA_W-1:0] o_Rdata1,
  output logic                o_MemWrite,
  output logic [P_ADDR_W-1:0] o_Address,
  output logic [P_DATA_W-1:0] o_Data,
  input  logic [P_DATA_W-1:0] i_ReadData
);

  arb_state_e          r_State, w_NextState;
  logic                r_Prio;
  logic                w_Arb0, w_Arb1;
  logic                w_Gnt0, w_Gnt1;
  logic                r_Rvalid0, r_Rvalid1;
  logic [P_DATA_W-1:0] r_Rdata0, r_Rdata1;

  rr_arb2 u_rr (
    .i_Req0  (i_Req0),
    .i_Req1  (i_Req1),
    .i_Prio  (r_Prio),
    .o_Pick0 (w_Arb0),
    .o_Pick1 (w_Arb1)
  );

  always_ff @(posedge i_Clock or negedge i_Reset) begin
    if (!i_Reset) r_State <= ST_IDLE;
    else          r_State <= w_NextState;
  end

  // Unreachable encoding 2'd3 falls into the IDLE branch via default.
  always_comb begin
    w_NextState = r_State;
    case (r_State)
      ST_LOCK0: if (w_Gnt0 && !i_Lock0) w_NextState = ST_IDLE;
      ST_LOCK1: if (w_Gnt1 && !i_Lock1) w_NextState = ST_IDLE;
      default: begin
        w_NextState = ST_IDLE;
        if      (w_Gnt0 && i_Lock0) w_NextState = ST_LOCK0;
        else if (w_Gnt1 && i_Lock1) w_NextState = ST_LOCK1;
      end
    endcase
  end

  always_comb begin
    w_Gnt0 = 1'b0;
    w_Gnt1 = 1'b0;
    if (i_Reset) begin
      case (r_State)
        ST_LOCK0: w_Gnt0 = i_Req0;
        ST_LOCK1: w_Gnt1 = i_Req1;
        default: begin
          w_Gnt0 = w_Arb0;
          w_Gnt1 = w_Arb1;
        end
      endcase
    end
  end

  // Any unlocked access (plain IDLE access or lock release) hands priority to the other port.
  always_ff @(posedge i_Clock or negedge i_Reset) begin
    if (!i_Reset)                 r_Prio <= 1'b0;
    else if (w_Gnt0 && !i_Lock0)  r_Prio <= 1'b1;
    else if (w_Gnt1 && !i_Lock1)  r_Prio <= 1'b0;
  end

  always_ff @(posedge i_Clock or negedge i_Reset) begin
    if (!i_Reset) begin
      r_Rvalid0 <= 1'b0;
      r_Rvalid1 <= 1'b0;
      r_Rdata0  <= '0;
      r_Rdata1  <= '0;
    end else begin
      r_Rvalid0 <= w_Gnt0 & ~i_We0;
      r_Rvalid1 <= w_Gnt1 & ~i_We1;
      if (w_Gnt0 && !i_We0) r_Rdata0 <= i_ReadData;
      if (w_Gnt1 && !i_We1) r_Rdata1 <= i_ReadData;
    end
  end

  assign o_Gnt0     = w_Gnt0;
  assign o_Gnt1     = w_Gnt1;
  assign o_MemWrite = (w_Gnt0 & i_We0) | (w_Gnt1 & i_We1);
  assign o_Address  = w_Gnt1 ? i_Addr1  : i_Addr0;
  assign o_Data     = w_Gnt1 ? i_Wdata1 : i_Wdata0;
  assign o_Rvalid0  = r_Rvalid0;
  assign o_Rvalid1  = r_Rvalid1;
  assign o_Rdata0   = r_Rdata0;
  assign o_Rdata1   = r_Rdata1;

endmodule

// File: tb/tb_dmem_arbiter.sv
// Directed table-driven bench for dmem_arbiter with a behavioural data_mem model.
module tb_dmem_arbiter;

  logic        clk = 1'b0;
  logic        rst;
  logic        req0, req1, we0, we1, lk0, lk1;
  logic [63:0] a0, a1, d0, d1;
  logic        gnt0, gnt1, rv0, rv1, mw;
  logic [63:0] rd0, rd1, maddr, mdata, mrd;
  logic [63:0] mem [0:31];

  int n_chk  = 0;
  int n_fail = 0;

  always #5 clk = ~clk;

  dmem_arbiter #(.P_ADDR_W(64), .P_DATA_W(64)) dut (
    .i_Clock(clk), .i_Reset(rst),
    .i_Req0(req0), .i_Req1(req1), .i_We0(we0), .i_We1(we1),
    .i_Lock0(lk0), .i_Lock1(lk1),
    .i_Addr0(a0), .i_Addr1(a1), .i_Wdata0(d0), .i_Wdata1(d1),
    .o_Gnt0(gnt0), .o_Gnt1(gnt1), .o_Rvalid0(rv0), .o_Rvalid1(rv1),
    .o_Rdata0(rd0), .o_Rdata1(rd1),
    .o_MemWrite(mw), .o_Address(maddr), .o_Data(mdata), .i_ReadData(mrd)
  );

  // data_mem: write on the edge, combinational read
  always @(posedge clk) if (mw) mem[maddr[4:0]] <= mdata;
  assign mrd = mem[maddr[4:0]];

  typedef struct {
    logic        r0, r1, w0, w1, l0, l1;
    logic [63:0] a0, a1, d0, d1;
    logic        g0, g1, mw, v0, v1;
    logic [63:0] q0, q1;
  } vec_t;

  vec_t tbl [23];

  function automatic vec_t mk(logic r0_, logic r1_, logic w0_, logic w1_, logic l0_, logic l1_,
                              logic [63:0] a0_, logic [63:0] a1_, logic [63:0] d0_, logic [63:0] d1_,
                              logic g0_, logic g1_, logic mw_, logic v0_, logic v1_,
                              logic [63:0] q0_, logic [63:0] q1_);
    vec_t v;
    v.r0 = r0_; v.r1 = r1_; v.w0 = w0_; v.w1 = w1_; v.l0 = l0_; v.l1 = l1_;
    v.a0 = a0_; v.a1 = a1_; v.d0 = d0_; v.d1 = d1_;
    v.g0 = g0_; v.g1 = g1_; v.mw = mw_; v.v0 = v0_; v.v1 = v1_;
    v.q0 = q0_; v.q1 = q1_;
    return v;
  endfunction

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  task automatic drive(input vec_t v);
    req0 = v.r0; req1 = v.r1; we0 = v.w0; we1 = v.w1; lk0 = v.l0; lk1 = v.l1;
    a0 = v.a0; a1 = v.a1; d0 = v.d0; d1 = v.d1;
  endtask

  initial begin
    //      r0 r1 w0 w1 l0 l1  a0 a1  d0        d1       g0 g1 mw v0 v1  q0        q1
    // release: both write, port 0 wins first; then single-port write/read
    tbl[0]  = mk(1,1,1,1,0,0, 1, 16, 'h1111,  'hB,      1,0,1, 0,0, 0,        0);
    tbl[1]  = mk(1,1,1,1,0,0, 8, 16, 'hA,     'hB,      0,1,1, 0,0, 0,        0);
    tbl[2]  = mk(1,0,1,0,0,0, 8, 0,  'hA,     0,        1,0,1, 0,0, 0,        0);
    tbl[3]  = mk(1,0,1,0,0,0, 0, 0,  'hFFFF,  0,        1,0,1, 0,0, 0,        0);
    tbl[4]  = mk(1,0,0,0,0,0, 0, 0,  0,       0,        1,0,0, 0,0, 0,        0);
    tbl[5]  = mk(0,1,0,0,0,0, 0, 16, 0,       0,        0,1,0, 1,0, 'hFFFF,   0);
    // contention: alternating grants, responses one cycle later
    tbl[6]  = mk(1,1,0,0,0,0, 8, 16, 0,       0,        1,0,0, 0,1, 'hFFFF,   'hB);
    tbl[7]  = mk(1,1,0,0,0,0, 8, 16, 0,       0,        0,1,0, 1,0, 'hA,      'hB);
    tbl[8]  = mk(1,1,0,0,0,0, 8, 16, 0,       0,        1,0,0, 0,1, 'hA,      'hB);
    tbl[9]  = mk(1,1,0,0,0,0, 8, 16, 0,       0,        0,1,0, 1,0, 'hA,      'hB);
    tbl[10] = mk(1,0,0,0,0,0, 8, 0,  0,       0,        1,0,0, 0,1, 'hA,      'hB);
    // port 1 lock: read then write while port 0 waits
    tbl[11] = mk(1,1,0,0,0,1, 1, 1,  0,       0,        0,1,0, 1,0, 'hA,      'hB);
    tbl[12] = mk(1,1,0,1,0,0, 1, 1,  0,       'hAFFFF,  0,1,1, 0,1, 'hA,      'h1111);
    tbl[13] = mk(1,0,0,0,0,0, 1, 0,  0,       0,        1,0,0, 0,0, 'hA,      'h1111);
    tbl[14] = mk(0,1,0,0,0,0, 0, 16, 0,       0,        0,1,0, 1,0, 'hAFFFF,  'h1111);
    // port 0 lock with a 3-cycle idle gap
    tbl[15] = mk(1,1,0,0,1,0, 0, 8,  0,       0,        1,0,0, 0,1, 'hAFFFF,  'hB);
    tbl[16] = mk(0,1,0,0,1,0, 0, 8,  0,       0,        0,0,0, 1,0, 'hFFFF,   'hB);
    tbl[17] = mk(0,1,0,0,1,0, 0, 8,  0,       0,        0,0,0, 0,0, 'hFFFF,   'hB);
    tbl[18] = mk(0,1,0,0,1,0, 0, 8,  0,       0,        0,0,0, 0,0, 'hFFFF,   'hB);
    tbl[19] = mk(1,1,1,0,0,0, 2, 8,  'h22,    0,        1,0,1, 0,0, 'hFFFF,   'hB);
    tbl[20] = mk(0,1,0,0,0,0, 0, 8,  0,       0,        0,1,0, 0,0, 'hFFFF,   'hB);
    tbl[21] = mk(1,0,0,0,0,0, 8, 0,  0,       0,        1,0,0, 0,1, 'hFFFF,   'hA);
    tbl[22] = mk(0,0,0,0,0,0, 0, 0,  0,       0,        0,0,0, 1,0, 'hA,      'hA);

    rst = 1'b0;
    req0 = 1'b1; req1 = 1'b1; we0 = 1'b1; we1 = 1'b0; lk0 = 1'b0; lk1 = 1'b0;
    a0 = '0; a1 = '0; d0 = '0; d1 = '0;
    @(posedge clk); #1;
    @(posedge clk); #3;
    chk("rst_gnt0", gnt0, 0);
    chk("rst_gnt1", gnt1, 0);
    chk("rst_memwrite", mw, 0);
    chk("rst_rvalid0", rv0, 0);
    chk("rst_rvalid1", rv1, 0);
    chk("rst_rdata0", rd0, 0);

    for (int i = 0; i < 23; i++) begin
      @(posedge clk); #1;
      if (i == 0) rst = 1'b1;
      drive(tbl[i]);
      #2;
      chk($sformatf("v%0d_gnt0", i), gnt0, tbl[i].g0);
      chk($sformatf("v%0d_gnt1", i), gnt1, tbl[i].g1);
      chk($sformatf("v%0d_memwrite", i), mw, tbl[i].mw);
      chk($sformatf("v%0d_rvalid0", i), rv0, tbl[i].v0);
      chk($sformatf("v%0d_rvalid1", i), rv1, tbl[i].v1);
      chk($sformatf("v%0d_rdata0", i), rd0, tbl[i].q0);
      chk($sformatf("v%0d_rdata1", i), rd1, tbl[i].q1);
    end

    // reset mid-lock: port 1 enters LOCK1 (pointer currently 1), reads again, reset hits that cycle
    @(posedge clk); #1;
    req0 = 0; req1 = 1; we1 = 0; lk1 = 1; a1 = 16;
    #2;
    chk("ml_lock_gnt1", gnt1, 1);
    @(posedge clk); #1;
    req0 = 1; we0 = 0; lk0 = 0; a0 = 8;
    #2;
    chk("ml_held_gnt0", gnt0, 0);
    chk("ml_read_gnt1", gnt1, 1);
    #1 rst = 1'b0;
    #1;
    chk("ml_rst_gnt1", gnt1, 0);
    chk("ml_rst_memwrite", mw, 0);
    @(posedge clk); #1;
    chk("ml_no_rvalid1", rv1, 0);
    chk("ml_rdata1_cleared", rd1, 0);
    rst = 1'b1; lk1 = 0;
    #2;
    chk("ml_release_gnt0", gnt0, 1);
    chk("ml_release_gnt1", gnt1, 0);
    @(posedge clk); #1;
    req0 = 0; req1 = 0;
    #2;
    chk("ml_rvalid0", rv0, 1);
    chk("ml_rdata0", rd0, 'hA);
    chk("ml_rvalid1_quiet", rv1, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
